// File: rtl/mollusc_pkg.sv
// Shared decode-stage types and sizing for the register scoreboard.
package mollusc_pkg;

  localparam int unsigned REG_ADDR_W  = 4;
  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned MAX_PENDING = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode-to-scoreboard handshake: instruction register fields plus ready/issue.
interface decode_scoreboard_if;
  import mollusc_pkg::*;

  logic      dec_valid;
  logic      dec_ready;
  reg_addr_t ra_pred;
  reg_addr_t ra_a;
  reg_addr_t ra_b;
  logic      use_b;
  reg_addr_t ra_mem;
  logic      use_mem;
  reg_addr_t ra_dest;
  logic      dest_en;
  logic      issue;

  modport master (
    output dec_valid, ra_pred, ra_a, ra_b, use_b, ra_mem, use_mem, ra_dest, dest_en,
    input  dec_ready, issue
  );

  modport slave (
    input  dec_valid, ra_pred, ra_a, ra_b, use_b, ra_mem, use_mem, ra_dest, dest_en,
    output dec_ready, issue
  );
endinterface

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module sb_counter #(
  parameter int unsigned MAX = 3,
  parameter int unsigned W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         underflow_c
);

  assign underflow_c = dec & (count == W'(0));

  // Simultaneous inc/dec cancels; never wraps in either direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= W'(0);
    end else begin
      case ({inc, dec})
        2'b10:   if (count != W'(MAX)) count <= count + W'(1);
        2'b01:   if (count != W'(0))   count <= count - W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard between decode and execute.
// Optional: SCOREBOARD_BYPASS_EN lets a source retiring its last write this cycle issue.
module decode_scoreboard
  import mollusc_pkg::*;
#(
  parameter int unsigned MAX_PENDING_P = MAX_PENDING
) (
  input  logic                clk,
  input  logic                rst,
  decode_scoreboard_if.slave  dec,
  input  logic                ex_ready,
  input  logic                flush,
  input  logic                wb_valid,
  input  reg_addr_t           wb_addr,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                sb_err
);

  localparam int unsigned CNT_W = $clog2(MAX_PENDING_P + 1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dcr;
  logic [NUM_REGS-1:0] underflow;
  logic [NUM_REGS-1:0] pend;
  logic                hazard;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    assign inc[g] = dec.issue & dec.dest_en & (dec.ra_dest == REG_ADDR_W'(g));
    assign dcr[g] = wb_valid & (wb_addr == REG_ADDR_W'(g));
    assign busy_mask[g] = (cnt[g] != CNT_W'(0));

    sb_counter #(.MAX(MAX_PENDING_P), .W(CNT_W)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc         (inc[g]),
      .dec         (dcr[g]),
      .count       (cnt[g]),
      .underflow_c (underflow[g])
    );
  end

  // Source-side pending view; with bypass, the final in-flight write forwards from writeback.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      pend[i] = (cnt[i] != CNT_W'(0));
`ifdef SCOREBOARD_BYPASS_EN
      if (dcr[i] && (cnt[i] == CNT_W'(1))) pend[i] = 1'b0;
`endif
    end
  end

  always_comb begin
    hazard = pend[dec.ra_pred]
           | pend[dec.ra_a]
           | (dec.use_b   & pend[dec.ra_b])
           | (dec.use_mem & pend[dec.ra_mem])
           | (dec.dest_en & (cnt[dec.ra_dest] == CNT_W'(MAX_PENDING_P)));
  end

  assign dec.dec_ready = ex_ready & ~hazard & ~flush & ~rst;
  assign dec.issue     = dec.dec_valid & dec.dec_ready;

  always_ff @(posedge clk) begin
    if (rst)             sb_err <= 1'b0;
    else if (|underflow) sb_err <= 1'b1;
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard; expectations queued at drive time, checked after settle.
module tb_decode_scoreboard;
  import mollusc_pkg::*;

  typedef struct {
    string       tag;
    logic        ready;
    logic        iss;
    logic [15:0] busy;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  reg_addr_t   wb_addr;
  logic [15:0] busy_mask;
  logic        sb_err;

  int   vectors = 0;
  int   errors  = 0;
  exp_t exp_q[$];

  decode_scoreboard_if sb_if ();

  decode_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .dec       (sb_if),
    .ex_ready  (ex_ready),
    .flush     (flush),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .busy_mask (busy_mask),
    .sb_err    (sb_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb_if.dec_valid = 1'b0;
    sb_if.ra_pred   = '0;
    sb_if.ra_a      = '0;
    sb_if.ra_b      = '0;
    sb_if.use_b     = 1'b0;
    sb_if.ra_mem    = '0;
    sb_if.use_mem   = 1'b0;
    sb_if.ra_dest   = '0;
    sb_if.dest_en   = 1'b0;
    ex_ready        = 1'b1;
    flush           = 1'b0;
    wb_valid        = 1'b0;
    wb_addr         = '0;
  endtask

  task automatic instr(reg_addr_t a, reg_addr_t b, logic ub, logic de, reg_addr_t d);
    sb_if.dec_valid = 1'b1;
    sb_if.ra_a      = a;
    sb_if.ra_b      = b;
    sb_if.use_b     = ub;
    sb_if.dest_en   = de;
    sb_if.ra_dest   = d;
  endtask

  task automatic wb(reg_addr_t r);
    wb_valid = 1'b1;
    wb_addr  = r;
  endtask

  // Queue expectation for the inputs just driven, then settle and check.
  task automatic step(string tag, logic rdy, logic [15:0] busy, logic err);
    exp_t e, p;
    e.tag = tag; e.ready = rdy; e.iss = sb_if.dec_valid & rdy; e.busy = busy; e.err = err;
    exp_q.push_back(e);
    #1;
    p = exp_q.pop_front();
    cmp({p.tag, ".ready"}, 16'(sb_if.dec_ready), 16'(p.ready));
    cmp({p.tag, ".issue"}, 16'(sb_if.issue),     16'(p.iss));
    cmp({p.tag, ".busy"},  busy_mask,            p.busy);
    cmp({p.tag, ".err"},   16'(sb_err),          16'(p.err));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    sb_if.dec_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); step("rst", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0; idle();
    step("rst_rel", 1'b1, 16'h0000, 1'b0);

    // RAW on r5
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd5); step("raw_wr5", 1'b1, 16'h0000, 1'b0);
    @(negedge clk); idle(); instr(4'd5, 4'd0, 1'b0, 1'b0, 4'd0); step("raw_stall", 1'b0, 16'h0020, 1'b0);
    @(negedge clk); wb(4'd5);
`ifdef SCOREBOARD_BYPASS_EN
    step("raw_wbcyc", 1'b1, 16'h0020, 1'b0);
`else
    step("raw_wbcyc", 1'b0, 16'h0020, 1'b0);
`endif
    @(negedge clk); idle(); instr(4'd5, 4'd0, 1'b0, 1'b0, 4'd0); step("raw_after", 1'b1, 16'h0000, 1'b0);

    // Immediate operand B masks the hazard
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd7); step("imm_wr7", 1'b1, 16'h0000, 1'b0);
    @(negedge clk); idle(); instr(4'd0, 4'd7, 1'b0, 1'b0, 4'd0); step("imm_nouse", 1'b1, 16'h0080, 1'b0);
    @(negedge clk); idle(); instr(4'd0, 4'd7, 1'b1, 1'b0, 4'd0); step("imm_useb", 1'b0, 16'h0080, 1'b0);
    @(negedge clk); idle(); sb_if.ra_mem = 4'd7; sb_if.use_mem = 1'b1; step("mem_stall", 1'b0, 16'h0080, 1'b0);
    @(negedge clk); idle(); wb(4'd7); step("imm_wb7", 1'b1, 16'h0080, 1'b0);

    // WAW and saturation on r3
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd3);
      step($sformatf("waw%0d", i), 1'b1, (i == 0) ? 16'h0000 : 16'h0008, 1'b0);
    end
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd3); step("sat_stall", 1'b0, 16'h0008, 1'b0);
    wb(4'd3); step("sat_wbcyc", 1'b0, 16'h0008, 1'b0);
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd3); step("sat_issue", 1'b1, 16'h0008, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); wb(4'd3); step($sformatf("drain%0d", i), 1'b1, 16'h0008, 1'b0);
    end
    @(negedge clk); idle(); step("drained", 1'b1, 16'h0000, 1'b0);

    // Simultaneous issue and retire on r2
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd2); step("sim_wr2", 1'b1, 16'h0000, 1'b0);
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd2); wb(4'd2); step("sim_both", 1'b1, 16'h0004, 1'b0);
    @(negedge clk); idle(); wb(4'd2); step("sim_hold", 1'b1, 16'h0004, 1'b0);
    @(negedge clk); idle(); step("sim_clear", 1'b1, 16'h0000, 1'b0);

    // Underflow sets the sticky error
    @(negedge clk); idle(); wb(4'd9); step("err_wb9", 1'b1, 16'h0000, 1'b0);
    @(negedge clk); idle(); step("err_set", 1'b1, 16'h0000, 1'b1);

    // Flush squashes issue while writebacks still retire
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd6); flush = 1'b1; step("flush", 1'b0, 16'h0000, 1'b1);
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd4); step("fl_wr4", 1'b1, 16'h0000, 1'b1);
    @(negedge clk); idle(); instr(4'd0, 4'd0, 1'b0, 1'b1, 4'd6); flush = 1'b1; wb(4'd4); step("fl_wb4", 1'b0, 16'h0010, 1'b1);
    @(negedge clk); idle(); step("fl_after", 1'b1, 16'h0000, 1'b1);

    // Execute backpressure; ready independent of valid
    @(negedge clk); idle(); ex_ready = 1'b0; step("exbp_idle", 1'b0, 16'h0000, 1'b1);
    instr(4'd0, 4'd0, 1'b0, 1'b0, 4'd0); step("exbp_valid", 1'b0, 16'h0000, 1'b1);

    // Reset clears the sticky error
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); step("rst2", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0; step("rst2_rel", 1'b1, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
